// File: rtl/cdc_mux_hs_sync_pkg.sv
// Shared types and limits for the hold-and-load CDC with toggle handshake.
package cdc_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } cdc_hs_state_t;

    localparam int CDC_SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_mux_hs_sync_sync_ndff.sv
// Single-bit N-flop synchroniser with asynchronous active-low reset.
module sync_ndff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_mux_hs_sync.sv
// Multi-bit clka -> clkb crossing: the source word is parked in a hold
// register and a toggle request tells the clkb side to load it. An ack toggle
// returns to clka before the next word is accepted.
// Optional feature macro: CDC_MUX_DST_BP_EN adds dst_ready back-pressure.
//
// state  | meaning
// S_IDLE | no word in flight, src_ready=1, accept on src_valid
// S_BUSY | word parked in hold, waiting for ack toggle to match req toggle
module cdc_mux_hs_sync
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clka,
    input  logic             rstna,
    input  logic             clkb,
    input  logic             rstnb,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic [WIDTH-1:0] dst_data,
    output logic             dst_valid
`ifdef CDC_MUX_DST_BP_EN
    ,
    input  logic             dst_ready
`endif
);

    if (SYNC_STAGES < CDC_SYNC_STAGES_MIN || WIDTH < 1) begin : g_param_check
        $error("cdc_mux_hs_sync: SYNC_STAGES must be >= %0d and WIDTH >= 1",
               CDC_SYNC_STAGES_MIN);
    end

    cdc_hs_state_t    state;
    logic             src_ready_q;
    logic [WIDTH-1:0] hold;
    logic             req_tgl;
    logic             ack_sync;

    logic             req_sync;
    logic             req_d;
    logic             ack_tgl;
    logic             new_evt;

    // Source FSM: park the word on acceptance, release when the ack catches up.
    always_ff @(posedge clka or negedge rstna) begin
        if (!rstna) begin
            state       <= S_IDLE;
            src_ready_q <= 1'b1;
            hold        <= '0;
            req_tgl     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (src_valid) begin
                        hold        <= src_data;
                        req_tgl     <= ~req_tgl;
                        state       <= S_BUSY;
                        src_ready_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // An arriving ack only returns to idle; the next word is
                    // accepted no earlier than the following cycle.
                    if (ack_sync == req_tgl) begin
                        state       <= S_IDLE;
                        src_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    src_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign src_ready = src_ready_q;

    sync_ndff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk  (clkb),
        .rstn (rstnb),
        .d    (req_tgl),
        .q    (req_sync)
    );

    sync_ndff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk  (clka),
        .rstn (rstna),
        .d    (ack_tgl),
        .q    (ack_sync)
    );

    assign new_evt = req_sync ^ req_d;

`ifdef CDC_MUX_DST_BP_EN
    // Destination: load hold on a new request, keep it until the consumer
    // takes it, and only then acknowledge so the source stalls meanwhile.
    always_ff @(posedge clkb or negedge rstnb) begin
        if (!rstnb) begin
            dst_data  <= '0;
            dst_valid <= 1'b0;
            req_d     <= 1'b0;
            ack_tgl   <= 1'b0;
        end else begin
            req_d <= req_sync;
            if (new_evt) begin
                dst_data  <= hold;
                dst_valid <= 1'b1;
            end else if (dst_valid && dst_ready) begin
                dst_valid <= 1'b0;
                ack_tgl   <= ~ack_tgl;
            end
        end
    end
`else
    // Destination: load hold on a new request as a one-cycle pulse and
    // acknowledge in the same cycle.
    always_ff @(posedge clkb or negedge rstnb) begin
        if (!rstnb) begin
            dst_data  <= '0;
            dst_valid <= 1'b0;
            req_d     <= 1'b0;
            ack_tgl   <= 1'b0;
        end else begin
            req_d     <= req_sync;
            dst_valid <= new_evt;
            if (new_evt) begin
                dst_data <= hold;
                ack_tgl  <= req_sync;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdc_mux_hs_sync.sv
// Bench for cdc_mux_hs_sync: an 8-bit/2-stage instance and a 32-bit/3-stage
// instance share adjustable clocks. Accepted words go into per-instance queues
// and a clkb-side monitor pops and compares data and latency.
module tb_cdc_mux_hs_sync;

    typedef struct {
        logic [31:0] data;
        int          cnt;
    } exp_t;

    int ha = 50;
    int hb = 135;

    logic clka, clkb, rstna, rstnb;

    logic        sv8, sr8, dv8;
    logic [7:0]  sd8, dd8;
    logic        sv32, sr32, dv32;
    logic [31:0] sd32, dd32;
    logic        rdy8, rdy32;

    exp_t q8[$];
    exp_t q32[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt_b = 0;
    int   rx8   = 0;
    int   rx32  = 0;
    logic dv8_prev  = 1'b0;
    logic dv32_prev = 1'b0;

    cdc_mux_hs_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clka      (clka),
        .rstna     (rstna),
        .clkb      (clkb),
        .rstnb     (rstnb),
        .src_valid (sv8),
        .src_data  (sd8),
        .src_ready (sr8),
        .dst_data  (dd8),
        .dst_valid (dv8)
`ifdef CDC_MUX_DST_BP_EN
        ,
        .dst_ready (rdy8)
`endif
    );

    cdc_mux_hs_sync #(.WIDTH(32), .SYNC_STAGES(3)) dut32 (
        .clka      (clka),
        .rstna     (rstna),
        .clkb      (clkb),
        .rstnb     (rstnb),
        .src_valid (sv32),
        .src_data  (sd32),
        .src_ready (sr32),
        .dst_data  (dd32),
        .dst_valid (dv32)
`ifdef CDC_MUX_DST_BP_EN
        ,
        .dst_ready (rdy32)
`endif
    );

    initial begin
        clka = 1'b0;
        forever #(ha) clka = ~clka;
    end

    initial begin
        clkb = 1'b0;
        forever #(hb) clkb = ~clkb;
    end

    always @(posedge clkb) cnt_b++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic chk_lat(input string nm, input int lat, input int stages);
        total++;
        if (lat < stages + 1 || lat > stages + 2) begin
            bad++;
            $display("FAIL %s: latency %0d clkb edges, expected %0d..%0d",
                     nm, lat, stages + 1, stages + 2);
        end
    endtask

    // Scoreboard push on every clka-side acceptance.
    always @(posedge clka) begin
        if (rstna && sv8 && sr8)
            q8.push_back('{data: {24'h0, sd8}, cnt: cnt_b});
        if (rstna && sv32 && sr32)
            q32.push_back('{data: sd32, cnt: cnt_b});
    end

    // Monitor: latency on the rising dst_valid, data on the consumer handshake.
    always @(negedge clkb) begin
        if (!rstnb) begin
            dv8_prev  = 1'b0;
            dv32_prev = 1'b0;
        end else begin
            if (dv8 && !dv8_prev) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected8: dst_data %h with no word pending", dd8);
                end else begin
                    chk_lat("lat8", cnt_b - q8[0].cnt, 2);
                end
            end
            if (dv8 && rdy8 && q8.size() > 0) begin
                chk("data8", {24'h0, dd8}, q8[0].data);
                void'(q8.pop_front());
                rx8++;
            end
            if (dv32 && !dv32_prev) begin
                if (q32.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected32: dst_data %h with no word pending", dd32);
                end else begin
                    chk_lat("lat32", cnt_b - q32[0].cnt, 3);
                end
            end
            if (dv32 && rdy32 && q32.size() > 0) begin
                chk("data32", dd32, q32[0].data);
                void'(q32.pop_front());
                rx32++;
            end
            dv8_prev  = dv8;
            dv32_prev = dv32;
        end
    end

    task automatic send(input bit wide, input logic [31:0] d);
        int g = 0;
        @(negedge clka);
        if (wide) begin sd32 = d; sv32 = 1'b1; end
        else begin sd8 = d[7:0]; sv8 = 1'b1; end
        while (((wide ? sr32 : sr8) == 1'b0) && g < 500) begin
            @(negedge clka);
            g++;
        end
        if (g >= 500) begin
            total++; bad++;
            $display("FAIL send_timeout: src_ready stayed 0, expected 1");
        end
        @(posedge clka);
        #1;
        chk(wide ? "busy32" : "busy8", {31'h0, wide ? sr32 : sr8}, 32'h0);
    endtask

    task automatic wait_ready(input bit wide);
        int g = 0;
        while (((wide ? sr32 : sr8) == 1'b0) && g < 2000) begin
            @(posedge clka);
            #1;
            g++;
        end
        chk(wide ? "ready32" : "ready8", {31'h0, wide ? sr32 : sr8}, 32'h1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((q8.size() != 0 || q32.size() != 0 || !sr8 || !sr32) && g < 4000) begin
            @(posedge clka);
            #1;
            g++;
        end
        chk("drain", q8.size() + q32.size(), 32'h0);
    endtask

    task automatic joint_reset();
        rstna = 1'b0;
        rstnb = 1'b0;
        q8.delete();
        q32.delete();
        repeat (5) @(posedge clka);
        repeat (5) @(posedge clkb);
        @(negedge clka);
        rstna = 1'b1;
        rstnb = 1'b1;
        #1;
    endtask

    initial begin
        #(20_000_000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx_before;
        int g;
        sv8 = 1'b0; sd8 = '0; sv32 = 1'b0; sd32 = '0;
        rdy8 = 1'b1; rdy32 = 1'b1;
        rstna = 1'b1; rstnb = 1'b1;
        #3;

        // 1: reset values and quiet outputs
        joint_reset();
        chk("rst_src_ready8", {31'h0, sr8}, 32'h1);
        chk("rst_dst_valid8", {31'h0, dv8}, 32'h0);
        chk("rst_dst_data8", {24'h0, dd8}, 32'h0);
        chk("rst_src_ready32", {31'h0, sr32}, 32'h1);
        chk("rst_dst_data32", dd32, 32'h0);
        repeat (50) @(posedge clkb);
        chk("rst_quiet", rx8 + rx32, 32'h0);

        // 2: single word, ack only after delivery
        rx_before = rx8;
        send(1'b0, 32'hA5);
        sv8 = 1'b0;
        wait_ready(1'b0);
        chk("ack_after_dst", rx8, rx_before + 1);
        chk("hold_dst_data", {24'h0, dd8}, 32'hA5);

        // 3: burst of 16 with src_valid held high
        rx_before = rx8;
        for (int i = 1; i <= 16; i++) send(1'b0, i);
        sv8 = 1'b0;
        wait_drain();
        chk("burst_count", rx8 - rx_before, 32'd16);
        chk("burst_last", {24'h0, dd8}, 32'h10);

        // 4: 32-bit / 3 stages, clkb 10x faster then 10x slower
        ha = 110; hb = 11;
        repeat (4) @(posedge clka);
        rx_before = rx32;
        for (int i = 0; i < 8; i++) send(1'b1, $urandom);
        sv32 = 1'b0;
        wait_drain();
        ha = 11; hb = 110;
        repeat (4) @(posedge clkb);
        for (int i = 0; i < 8; i++) send(1'b1, $urandom);
        sv32 = 1'b0;
        wait_drain();
        chk("ratio_count", rx32 - rx_before, 32'd16);
        ha = 50; hb = 135;
        repeat (4) @(posedge clkb);

`ifdef CDC_MUX_DST_BP_EN
        // 5: consumer back-pressure holds the word and stalls the source
        @(posedge clkb); #1;
        rdy8 = 1'b0;
        send(1'b0, 32'h3C);
        sv8 = 1'b0;
        g = 0;
        while (!dv8 && g < 200) begin @(negedge clkb); g++; end
        chk("bp_arrived", {31'h0, dv8}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clkb);
            chk("bp_valid", {31'h0, dv8}, 32'h1);
            chk("bp_data", {24'h0, dd8}, 32'h3C);
            chk("bp_src_stall", {31'h0, sr8}, 32'h0);
        end
        @(posedge clkb); #1;
        rdy8 = 1'b1;
        wait_drain();
        chk("bp_released", {31'h0, dv8}, 32'h0);
`endif

        // 6: joint reset while a word is in flight
        rx_before = rx8;
        send(1'b0, 32'h77);
        sv8 = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        joint_reset();
        chk("mid_rst_src_ready", {31'h0, sr8}, 32'h1);
        chk("mid_rst_dst_valid", {31'h0, dv8}, 32'h0);
        chk("mid_rst_dst_data", {24'h0, dd8}, 32'h0);
        repeat (50) @(posedge clkb);
        chk("mid_rst_no_stale", rx8, rx_before);

        // Post-reset sanity: a fresh word still crosses
        send(1'b0, 32'h5A);
        sv8 = 1'b0;
        wait_drain();
        chk("post_rst_word", {24'h0, dd8}, 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
